// File: rtl/apb_slave_regfile.sv
// APB completer in front of a bank of read/write registers.
// Supports programmable wait states, byte-lane writes and an error response on bad addresses.
// Each committed write produces a one-cycle notification carrying the register index.
module apb_slave_regfile #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_CYCLES = 1,
   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR,
   output logic                    wr_strobe,
   output logic [IW-1:0]           wr_index
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int B  = $clog2(NB);
   localparam int XW = ADDR_WIDTH - B;
   localparam logic [XW:0] NUM_REGS_V = (XW + 1)'(NUM_REGS);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                state, next_state;
   logic [3:0]            cnt, next_cnt;
   logic [XW-1:0]         idx;
   logic [IW-1:0]         ridx;
   logic                  bad;
   logic                  commit;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   // Full word index is used for the range check; the truncated one only
   // addresses the array, and is masked by bad whenever it would be out of range.
   assign idx    = PADDR[ADDR_WIDTH-1:B];
   assign ridx   = idx[IW-1:0];
   assign bad    = (PADDR[B-1:0] != '0) || ({1'b0, idx} >= NUM_REGS_V);
   assign commit = PREADY && PWRITE && !bad;

   assign PSLVERR = PREADY && bad;
   assign PRDATA  = (PREADY && !PWRITE && !bad) ? regs[ridx] : '0;

   // Transfer state and wait-state counter.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Next-state decode and PREADY; a master that stays in setup while in ACCESS freezes the counter.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      PREADY     = 1'b0;
      case (state)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               next_state = ACCESS;
               next_cnt   = WAIT_CYCLES[3:0];
            end
         end
         ACCESS: begin
            if (!PSEL) begin
               next_state = IDLE;
            end else if (PENABLE) begin
               if (cnt == 4'd0) begin
                  PREADY     = 1'b1;
                  next_state = IDLE;
               end else begin
                  next_cnt = cnt - 4'd1;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Register bank with byte-lane writes and the write notification.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         wr_strobe <= 1'b0;
         wr_index  <= '0;
      end else begin
         wr_strobe <= commit;
         if (commit) begin
            wr_index <= ridx;
            for (int k = 0; k < NB; k++) begin
               if (PSTRB[k]) regs[ridx][8*k +: 8] <= PWDATA[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: one instance with a wait state, one zero-wait instance.
module tb_apb_slave_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  paddr = '0;
   logic        psel0 = 1'b0, psel1 = 1'b0;
   logic        penable = 1'b0, pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;

   logic [31:0] prdata0, prdata1;
   logic        pready0, pready1, pslverr0, pslverr1, wr_strobe0, wr_strobe1;
   logic [3:0]  wr_index0, wr_index1;

   int checks = 0;
   int failures = 0;
   int sc0 = 0;
   int sc1 = 0;

   logic [31:0] rd;
   logic        er;
   int          cyc;

   always #5 clk = ~clk;

   apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(1)) dut0 (
      .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PSEL(psel0), .PENABLE(penable),
      .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0),
      .PREADY(pready0), .PSLVERR(pslverr0), .wr_strobe(wr_strobe0), .wr_index(wr_index0)
   );

   apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_CYCLES(0)) dut1 (
      .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PSEL(psel1), .PENABLE(penable),
      .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata1),
      .PREADY(pready1), .PSLVERR(pslverr1), .wr_strobe(wr_strobe1), .wr_index(wr_index1)
   );

   // Count write-notification pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_strobe0) sc0 <= sc0 + 1;
      if (wr_strobe1) sc1 <= sc1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // One complete transfer; returns right after PREADY is seen so a following
   // call issues its setup in the very next cycle.
   task automatic apb_xfer(input int d, input logic wr, input logic [7:0] a,
                           input logic [31:0] wd, input logic [3:0] st,
                           output logic [31:0] rdata, output logic err, output int cycles);
      bit done;
      done = 0;
      rdata = '0;
      err = 1'b0;
      @(negedge clk);
      if (d == 0) psel0 = 1'b1; else psel1 = 1'b1;
      penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
      cycles = 1;
      @(negedge clk);
      penable = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         cycles++;
         if ((d == 0) ? pready0 : pready1) begin
            rdata = (d == 0) ? prdata0 : prdata1;
            err   = (d == 0) ? pslverr0 : pslverr1;
            done  = 1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) chk("xfer_timeout", 32'd0, 32'd1);
   endtask

   task automatic bus_idle();
      @(negedge clk);
      psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
      #1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_pready", {31'd0, pready0}, 32'd0);
      chk("rst_prdata", prdata0, 32'd0);
      chk("rst_pslverr", {31'd0, pslverr0}, 32'd0);
      chk("rst_wr_strobe", {31'd0, wr_strobe0}, 32'd0);
      chk("rst_wr_index", {28'd0, wr_index0}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 1: read idx 3 after reset, one wait state
      apb_xfer(0, 1'b0, 8'h0C, 32'd0, 4'h0, rd, er, cyc);
      chk("t1_rdata", rd, 32'd0);
      chk("t1_err", {31'd0, er}, 32'd0);
      chk("t1_cycles", cyc, 32'd3);
      bus_idle();

      // 2: full write then single-lane write to idx 2
      apb_xfer(0, 1'b1, 8'h08, 32'hDEADBEEF, 4'hF, rd, er, cyc);
      chk("t2_w1_err", {31'd0, er}, 32'd0);
      bus_idle();
      chk("t2_strobe1", {31'd0, wr_strobe0}, 32'd1);
      chk("t2_index1", {28'd0, wr_index0}, 32'd2);
      apb_xfer(0, 1'b1, 8'h08, 32'h000000AA, 4'h1, rd, er, cyc);
      bus_idle();
      chk("t2_strobe2", {31'd0, wr_strobe0}, 32'd1);
      bus_idle();
      chk("t2_strobe_low", {31'd0, wr_strobe0}, 32'd0);
      apb_xfer(0, 1'b0, 8'h08, 32'd0, 4'h0, rd, er, cyc);
      chk("t2_rdata", rd, 32'hDEADBEAA);
      bus_idle();
      chk("t2_pulses", sc0, 32'd2);
      chk("t2_index", {28'd0, wr_index0}, 32'd2);

      // Zero strobes: no data change, notification still pulses
      apb_xfer(0, 1'b1, 8'h08, 32'h11111111, 4'h0, rd, er, cyc);
      chk("strb0_err", {31'd0, er}, 32'd0);
      bus_idle();
      apb_xfer(0, 1'b0, 8'h08, 32'd0, 4'h0, rd, er, cyc);
      chk("strb0_rdata", rd, 32'hDEADBEAA);
      bus_idle();
      chk("strb0_pulses", sc0, 32'd3);

      // 3: out-of-range read and misaligned write
      apb_xfer(0, 1'b0, 8'h40, 32'd0, 4'h0, rd, er, cyc);
      chk("t3_rd_err", {31'd0, er}, 32'd1);
      chk("t3_rd_data", rd, 32'd0);
      bus_idle();
      apb_xfer(0, 1'b1, 8'h05, 32'hFFFFFFFF, 4'hF, rd, er, cyc);
      chk("t3_wr_err", {31'd0, er}, 32'd1);
      bus_idle();
      chk("t3_no_strobe", {31'd0, wr_strobe0}, 32'd0);
      apb_xfer(0, 1'b0, 8'h04, 32'd0, 4'h0, rd, er, cyc);
      chk("t3_reg1", rd, 32'd0);
      bus_idle();
      chk("t3_pulses", sc0, 32'd3);

      // 4: zero-wait back-to-back write/read, no idle gap
      apb_xfer(1, 1'b1, 8'h04, 32'h12345678, 4'hF, rd, er, cyc);
      chk("t4_w_cycles", cyc, 32'd2);
      apb_xfer(1, 1'b0, 8'h04, 32'd0, 4'h0, rd, er, cyc);
      chk("t4_r_cycles", cyc, 32'd2);
      chk("t4_rdata", rd, 32'h12345678);
      chk("t4_r_err", {31'd0, er}, 32'd0);
      bus_idle();
      chk("t4_pulses", sc1, 32'd1);
      chk("t4_index", {28'd0, wr_index1}, 32'd1);

      // 5a: abort a write to idx 0 during its wait state
      apb_xfer(0, 1'b1, 8'h00, 32'h00000011, 4'hF, rd, er, cyc);
      bus_idle();
      @(negedge clk);
      psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h00000055; pstrb = 4'hF;
      @(negedge clk);
      penable = 1'b1;
      #1;
      chk("t5_wait_pready", {31'd0, pready0}, 32'd0);
      psel0 = 1'b0; penable = 1'b0;
      bus_idle();
      chk("t5_abort_strobe", {31'd0, wr_strobe0}, 32'd0);
      apb_xfer(0, 1'b0, 8'h00, 32'd0, 4'h0, rd, er, cyc);
      chk("t5_reg0", rd, 32'h00000011);
      chk("t5_idle_cycles", cyc, 32'd3);
      bus_idle();
      chk("t5_pulses", sc0, 32'd4);

      // 5b: reset while PREADY is high in ACCESS
      @(negedge clk);
      psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h00000077; pstrb = 4'hF;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      #1;
      chk("t5_pre_rst_pready", {31'd0, pready0}, 32'd1);
      rst = 1'b1;
      #1;
      chk("t5_rst_pready", {31'd0, pready0}, 32'd0);
      psel0 = 1'b0; penable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      apb_xfer(0, 1'b0, 8'h00, 32'd0, 4'h0, rd, er, cyc);
      chk("t5_clr_reg0", rd, 32'd0);
      apb_xfer(0, 1'b0, 8'h04, 32'd0, 4'h0, rd, er, cyc);
      chk("t5_clr_reg1", rd, 32'd0);
      apb_xfer(0, 1'b0, 8'h08, 32'd0, 4'h0, rd, er, cyc);
      chk("t5_clr_reg2", rd, 32'd0);
      bus_idle();
      chk("t5_clr_index", {28'd0, wr_index0}, 32'd0);

      // 6: PENABLE without a setup phase is ignored
      @(negedge clk);
      psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t6_pready", {31'd0, pready0}, 32'd0);
         @(negedge clk);
      end
      psel0 = 1'b0; penable = 1'b0;
      bus_idle();
      chk("t6_no_strobe", {31'd0, wr_strobe0}, 32'd0);
      apb_xfer(0, 1'b0, 8'h0C, 32'd0, 4'h0, rd, er, cyc);
      chk("t6_reg3", rd, 32'd0);
      chk("t6_cycles", cyc, 32'd3);
      bus_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
